// File: rtl/popcnt_seq.sv
// -----------------------------------------------------------------------------
// popcnt_seq -- sequential population count of a wide input word.
//
// The word is accepted in one cycle, then consumed CHUNK_W bits per cycle
// through a small combinational popcount (vec_add).  Counting stops early as
// soon as no set bits remain above the chunk just processed, so sparse words
// with only low-order bits finish in fewer cycles.
//
// vec_add      : combinational count of set bits in a DATA_W-bit vector.
//
// popcnt_seq ports
//   clk        in   1       sole clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       in_data is valid
//   in_ready   out  1       high in IDLE: a word is accepted this cycle
//   in_data    in   IN_W    word to be counted
//   out_valid  out  1       high in DONE: out_count/out_chunks are valid
//   out_ready  in   1       consumer takes the result this cycle
//   out_count  out  CNT_W   number of set bits in the accepted word
//   out_chunks out  IDX_W   number of chunks actually processed (1..NUM_CHUNKS)
//   busy       out  1       high in COUNT
// -----------------------------------------------------------------------------

module vec_add #(
   parameter int DATA_W = 10,
   parameter int POS_W  = 4
) (
   input  logic [DATA_W-1:0] vec_i,
   output logic [POS_W-1:0]  sum_o
);

   always_comb begin
      sum_o = '0;
      for (int i = 0; i < DATA_W; i++) begin
         sum_o = sum_o + POS_W'(vec_i[i]);
      end
   end

endmodule

module popcnt_seq #(
   parameter int CHUNK_W    = 10,
   parameter int NUM_CHUNKS = 4
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic [CHUNK_W*NUM_CHUNKS-1:0]            in_data,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [$clog2(CHUNK_W*NUM_CHUNKS+1)-1:0]  out_count,
   output logic [$clog2(NUM_CHUNKS+1)-1:0]          out_chunks,
   output logic                                     busy
);

   localparam int IN_W  = CHUNK_W * NUM_CHUNKS;
   localparam int CNT_W = $clog2(IN_W + 1);
   localparam int PC_W  = $clog2(CHUNK_W + 1);
   localparam int IDX_W = $clog2(NUM_CHUNKS + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_COUNT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IN_W-1:0]    sh_q, sh_d;
   logic [CNT_W-1:0]   acc_q, acc_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   out_count_q, out_count_d;
   logic [IDX_W-1:0]   out_chunks_q, out_chunks_d;

   logic [PC_W-1:0]    pc_sum;
   logic [IN_W-1:0]    sh_next;
   logic [CNT_W-1:0]   acc_next;
   logic [IDX_W-1:0]   idx_next;
   logic               last_chunk;

   // Popcount of the chunk currently at the bottom of the shift register.
   vec_add #(
      .DATA_W (CHUNK_W),
      .POS_W  (PC_W)
   ) u_pc (
      .vec_i (sh_q[CHUNK_W-1:0]),
      .sum_o (pc_sum)
   );

   // Values produced by one COUNT step.  acc cannot overflow: its maximum
   // is IN_W, which CNT_W is sized to hold.
   assign sh_next  = sh_q >> CHUNK_W;
   assign acc_next = acc_q + CNT_W'(pc_sum);
   assign idx_next = idx_q + IDX_W'(1);

   // Stop on the final chunk, or early once nothing set remains above it.
   assign last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1)) || (sh_next == '0);

   always_comb begin
      state_d      = state_q;
      sh_d         = sh_q;
      acc_d        = acc_q;
      idx_d        = idx_q;
      out_count_d  = out_count_q;
      out_chunks_d = out_chunks_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               sh_d    = in_data;
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_COUNT;
            end
         end
         S_COUNT: begin
            sh_d  = sh_next;
            acc_d = acc_next;
            idx_d = idx_next;
            if (last_chunk) begin
               // Results are only ever loaded here, so they stay stable
               // through the following IDLE and COUNT phases.
               out_count_d  = acc_next;
               out_chunks_d = idx_next;
               state_d      = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         sh_q         <= '0;
         acc_q        <= '0;
         idx_q        <= '0;
         out_count_q  <= '0;
         out_chunks_q <= '0;
      end else begin
         state_q      <= state_d;
         sh_q         <= sh_d;
         acc_q        <= acc_d;
         idx_q        <= idx_d;
         out_count_q  <= out_count_d;
         out_chunks_q <= out_chunks_d;
      end
   end

   // Handshake flags depend on the registered state only.
   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign busy       = (state_q == S_COUNT);
   assign out_count  = out_count_q;
   assign out_chunks = out_chunks_q;

endmodule
